// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle control unit and datapath
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, FWD} operation_t;
   typedef enum logic {LOW, HIGH} flag_t;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} ctrl_state_t;
   typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} a_sel_t;
   typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1} b_sel_t;
   typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} wb_sel_t;
   typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_type_t;

   typedef enum logic [3:0] {
      CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
      CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BAD
   } op_class_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   function automatic op_class_t opcode_class(input logic [6:0] opc);
      case (opc)
         OPC_OP:     return CL_OP;
         OPC_OPIMM:  return CL_OPIMM;
         OPC_LOAD:   return CL_LOAD;
         OPC_STORE:  return CL_STORE;
         OPC_BRANCH: return CL_BRANCH;
         OPC_LUI:    return CL_LUI;
         OPC_AUIPC:  return CL_AUIPC;
         OPC_JAL:    return CL_JAL;
         OPC_JALR:   return CL_JALR;
         default:    return CL_BAD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bundle between the sequencer (master) and datapath/memory (slave)
interface multicycle_ctrl_if #(parameter int XLEN = 32);
   import multicycle_ctrl_pkg::*;

   logic [XLEN-1:0] instr;
   logic            mem_ready;
   flag_t           alu_z;
   operation_t      alu_op;
   a_sel_t          a_sel;
   b_sel_t          b_sel;
   imm_type_t       imm_type;
   wb_sel_t         wb_sel;
   logic            ir_we;
   logic            pc_we;
   logic            pc_src;
   logic            reg_we;
   logic            mem_req;
   logic            mem_we;
   logic            illegal;

   modport master (
      input  instr, mem_ready, alu_z,
      output alu_op, a_sel, b_sel, imm_type, wb_sel,
             ir_we, pc_we, pc_src, reg_we, mem_req, mem_we, illegal
   );

   modport slave (
      output instr, mem_ready, alu_z,
      input  alu_op, a_sel, b_sel, imm_type, wb_sel,
             ir_we, pc_we, pc_src, reg_we, mem_req, mem_we, illegal
   );

endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// rtl/multicycle_ctrl_alu_op_decode.sv - {opcode class, funct3, funct7[5]} to ALU operation plus illegal flag
module alu_op_decode
   import multicycle_ctrl_pkg::*;
(
   input  op_class_t  cls,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output operation_t op,
   output logic       bad
);

   always_comb begin
      op  = ADD;
      bad = 1'b0;
      case (cls)
         CL_OP, CL_OPIMM: begin
            case (funct3)
               3'b000: if (cls == CL_OP && funct7b5) op = SUB; else op = ADD;
               3'b001: op = SLL;
               3'b010: op = SLT;
               3'b011: op = SLTU;
               3'b100: op = XOR;
               3'b101: if (funct7b5) op = SRA; else op = SRL;
               3'b110: op = OR;
               3'b111: op = AND;
               default: op = ADD;
            endcase
         end
         CL_LOAD, CL_STORE: bad = (funct3 != 3'b010);
         CL_BRANCH: begin
            // ALU reports zero on less-than, so SLT/SLTU double as the ordered compares
            case (funct3[2:1])
               2'b00:   op = SUB;
               2'b10:   op = SLT;
               2'b11:   op = SLTU;
               default: bad = 1'b1;
            endcase
         end
         CL_LUI:  op = FWD;
         CL_BAD:  bad = 1'b1;
         default: op = ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle sequencer: FETCH, DECODE, EXEC, MEM, WB
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic clk,
   input  logic rstN,
   multicycle_ctrl_if.master bus
);

   ctrl_state_t     state, state_nxt;
   logic            tgt, tgt_nxt;
   logic            active;
   logic [XLEN-1:0] ir;
   op_class_t       cls;
   operation_t      dec_op;
   logic            dec_bad;
   logic            illegal_enc;
   logic            taken;
   logic            ir_unused;

   assign cls         = opcode_class(ir[6:0]);
   assign illegal_enc = dec_bad || (cls == CL_OP && (ir[31] || (|ir[29:25])));
   assign taken       = ir[12] ? (bus.alu_z == LOW) : (bus.alu_z == HIGH);
   assign ir_unused   = ^{ir[24:15], ir[11:7]};

   alu_op_decode u_dec (
      .cls      (cls),
      .funct3   (ir[14:12]),
      .funct7b5 (ir[30]),
      .op       (dec_op),
      .bad      (dec_bad)
   );

   // active holds every strobe low from reset until the first edge after release
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state  <= FETCH;
         tgt    <= 1'b0;
         active <= 1'b0;
         ir     <= '0;
      end else begin
         state  <= state_nxt;
         tgt    <= tgt_nxt;
         active <= 1'b1;
         if (bus.ir_we) ir <= bus.instr;
      end
   end

   always_comb begin
      state_nxt    = state;
      tgt_nxt      = tgt;
      bus.alu_op   = ADD;
      bus.a_sel    = A_RS1;
      bus.b_sel    = B_RS2;
      bus.imm_type = IMM_I;
      bus.wb_sel   = WB_ALU;
      bus.ir_we    = 1'b0;
      bus.pc_we    = 1'b0;
      bus.pc_src   = 1'b0;
      bus.reg_we   = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.illegal  = 1'b0;
      if (active) begin
         case (state)
            FETCH: begin
               bus.mem_req = 1'b1;
               if (bus.mem_ready) begin
                  bus.ir_we = 1'b1;
                  bus.pc_we = 1'b1;
                  state_nxt = DECODE;
               end
            end
            DECODE: begin
               if (illegal_enc) begin
                  bus.illegal = 1'b1;
                  state_nxt   = FETCH;
               end else begin
                  state_nxt = EXEC;
               end
            end
            EXEC: begin
               bus.alu_op = dec_op;
               case (cls)
                  CL_OP:    state_nxt = WB;
                  CL_OPIMM: begin bus.b_sel = B_IMM; state_nxt = WB; end
                  CL_LOAD:  begin bus.b_sel = B_IMM; state_nxt = MEM; end
                  CL_STORE: begin bus.b_sel = B_IMM; bus.imm_type = IMM_S; state_nxt = MEM; end
                  CL_LUI: begin
                     bus.a_sel = A_ZERO; bus.b_sel = B_IMM; bus.imm_type = IMM_U;
                     state_nxt = WB;
                  end
                  CL_AUIPC: begin
                     bus.a_sel = A_PC; bus.b_sel = B_IMM; bus.imm_type = IMM_U;
                     state_nxt = WB;
                  end
                  CL_JAL: begin
                     bus.a_sel = A_PC; bus.b_sel = B_IMM; bus.imm_type = IMM_J;
                     bus.pc_we = 1'b1; bus.pc_src = 1'b1;
                     state_nxt = WB;
                  end
                  CL_JALR: begin
                     bus.b_sel = B_IMM;
                     bus.pc_we = 1'b1; bus.pc_src = 1'b1;
                     state_nxt = WB;
                  end
                  CL_BRANCH: begin
                     bus.imm_type = IMM_B;
                     if (!tgt) begin
                        if (taken) tgt_nxt = 1'b1;
                        else       state_nxt = FETCH;
                     end else begin
                        // second sub-cycle: the ALU is free to form old_pc + imm B
                        bus.alu_op = ADD; bus.a_sel = A_PC; bus.b_sel = B_IMM;
                        bus.pc_we  = 1'b1; bus.pc_src = 1'b1;
                        tgt_nxt    = 1'b0;
                        state_nxt  = FETCH;
                     end
                  end
                  default: state_nxt = FETCH;
               endcase
            end
            MEM: begin
               bus.alu_op   = ADD;
               bus.b_sel    = B_IMM;
               bus.imm_type = (cls == CL_STORE) ? IMM_S : IMM_I;
               bus.mem_req  = 1'b1;
               bus.mem_we   = (cls == CL_STORE);
               if (bus.mem_ready) state_nxt = (cls == CL_STORE) ? FETCH : WB;
            end
            WB: begin
               bus.reg_we = 1'b1;
               case (cls)
                  CL_LOAD:         bus.wb_sel = WB_MEM;
                  CL_JAL, CL_JALR: bus.wb_sel = WB_PC;
                  default:         bus.wb_sel = WB_ALU;
               endcase
               state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback. It is the issuing side of the ALU interface. It drives the ALU operation select and the operand, writeback and memory-side strobes, and it consumes the ALU zero flag to resolve branches. It sits between the instruction register and memory handshake on one side and the datapath muxes, register file and ALU on the other.

## Interface
- `XLEN`, default 32: instruction/datapath width. Only 32 is supported.
- `clk` input 1: single clock; all state updates on rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `instr` input 32: memory read data. Sampled when `mem_ready` is high in FETCH.
- `mem_ready` input 1: memory completion for the current `mem_req`.
- `alu_z` input `flag_t`: ALU zero flag for the current operation.
- `alu_op` output `operation_t`: ALU operation select.
- `a_sel` output 2: operand A source. 0 = rs1, 1 = old_pc, 2 = zero.
- `b_sel` output 2: operand B source. 0 = rs2, 1 = immediate.
- `imm_type` output 3: immediate format. 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `wb_sel` output 2: writeback source. 0 = ALU out, 1 = memory data, 2 = pc (already incremented).
- `ir_we` output 1: load instruction register and old_pc.
- `pc_we` output 1: write PC.
- `pc_src` output 1: PC source. 0 = pc+4 incrementer, 1 = ALU out.
- `reg_we` output 1: register file write enable.
- `mem_req` output 1: memory request.
- `mem_we` output 1: memory write (store).
- `illegal` output 1: one-cycle pulse on an unsupported encoding.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - Hold `mem_req`=1, `mem_we`=0 until `mem_ready`.
  - On `mem_ready`: pulse `ir_we`, and pulse `pc_we` with `pc_src`=0. Go to DECODE.
- DECODE:
  - Register the opcode, funct3 and funct7[5] fields of the IR copy.
  - Unsupported opcode or funct combination: pulse `illegal`, go to FETCH. PC is already advanced.
  - Otherwise go to EXEC.
- Supported opcodes:
  - OP 0110011, OP-IMM 0010011.
  - LOAD 0000011 with funct3=010 only; STORE 0100011 with funct3=010 only.
  - BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- OP funct3 mapping:
  - 000 → ADD, or SUB when funct7[5]=1.
  - 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR.
  - 101 → SRL, or SRA when funct7[5]=1.
  - 110 → OR, 111 → AND.
  - Any funct7 bit other than bit 5 set → illegal.
- OP-IMM: same mapping as OP, except funct3=000 is always ADD.
- EXEC:
  - R/I type: a=rs1. b=rs2 (OP) or imm I (OP-IMM). Go to WB.
  - LOAD/STORE: ADD, a=rs1, b=imm (I or S). Go to MEM.
  - LUI: FWD, a=zero, b=imm U. Go to WB.
  - AUIPC: ADD, a=old_pc, b=imm U. Go to WB.
  - BRANCH on BEQ/BNE: SUB, a=rs1, b=rs2.
  - BRANCH on BLT/BGE: SLT. On BLTU/BGEU: SLTU. The team ALU returns zero when a<b, so `alu_z`=HIGH means less-than.
  - Branch taken when:
    - BEQ: z. BNE: !z.
    - BLT/BLTU: z. BGE/BGEU: !z.
  - Branch funct3 010/011 → illegal (flagged in DECODE).
  - Taken branch: the same cycle the compare runs cannot also compute the target, so EXEC takes two sub-cycles via an internal `tgt` bit.
    - Cycle 1: compare.
    - Cycle 2 (taken only): ADD, a=old_pc, b=imm B, `pc_we`=1, `pc_src`=1. Then FETCH.
  - Not-taken branch: straight to FETCH after cycle 1.
  - JAL: ADD, a=old_pc, b=imm J. JALR: ADD, a=rs1, b=imm I.
  - JAL/JALR: `pc_we`=1, `pc_src`=1, then WB. The datapath clears the JALR target's bit 0.
- MEM:
  - Hold `mem_req`=1, with `mem_we`=1 for stores.
  - Keep the ALU address stable: hold the EXEC ALU selects.
  - On `mem_ready`: stores go to FETCH, loads go to WB.
- WB:
  - `reg_we`=1 for one cycle.
  - `wb_sel`: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - Go to FETCH.
- Idle defaults: all strobes 0, `alu_op`=ADD, all selects 0.

## Timing
- Reset (rstN=0, asynchronous):
  - State = FETCH, `tgt`=0, all strobes 0, `alu_op`=ADD.
  - The first request is issued in the first cycle after release.
- Reset mid-transaction aborts immediately; the memory side must tolerate the dropped `mem_req`.
- Cycle counts at zero wait states (`mem_ready` high in the first request cycle):
  - ALU, LUI, AUIPC: 4.
  - Load: 5. Store: 4.
  - Branch: 3 not taken, 4 taken.
  - JAL, JALR: 4.
  - Illegal: 2.
- Each wait cycle on `mem_ready` adds exactly one cycle.
- `ir_we`, `pc_we`, `reg_we` and `illegal` are single-cycle pulses. No two of `ir_we`/`reg_we` ever coincide.
- `mem_ready` is ignored outside FETCH and MEM.
- `alu_z` is sampled only in EXEC cycle 1 of a branch.

## Structure
- Opcode localparams, the state enum `ctrl_state_t`, and the select encodings (`a_sel_t`, `b_sel_t`, `wb_sel_t`, `imm_type_t`) go into the shared package alongside `operation_t`/`flag_t` in `alu_definitions`. The datapath imports the same encodings.
- One natural sub-module: `alu_op_decode`. It is combinational, maps {opcode class, funct3, funct7[5]} → `operation_t` plus an illegal bit, and is reused by the FSM in DECODE and EXEC.

## Test plan
- Reset release, `mem_ready`=1, instr=0x002081B3 (add x3,x1,x2) → FETCH/DECODE/EXEC/WB in 4 cycles; `alu_op`=ADD, b_sel=0, `reg_we` in cycle 4, `wb_sel`=0.
- instr=0x4020D1B3 (sra) → `alu_op`=SRA. instr=0x0020F193 (andi) → `alu_op`=AND, b_sel=1, imm_type=0.
- instr=0x0000A183 (lw) with `mem_ready` low for 3 MEM cycles → 8 cycles total; `mem_we`=0; `wb_sel`=1 at WB.
- instr=0x00208463 (beq): `alu_z`=HIGH → 4 cycles, cycle 4 `pc_we`=1, `pc_src`=1, a_sel=1, imm_type=2. `alu_z`=LOW → 3 cycles, no second `pc_we`.
- instr=0x0000100F and funct7=0x01 OP (mul) → `illegal` pulses in cycle 2, no `reg_we`, next FETCH in cycle 3.
- Assert rstN low during MEM of a store → all outputs 0 asynchronously; after release, FETCH restarts with `mem_req`=1.
